// File: rtl/fifo_tx_pkg.sv
// fifo_tx_pkg
// Shared definitions for the FIFO-fed serial nibble transmitter:
//   - tx_state_t   : frame sequencer states
//   - frame_cycles : clk cycles in one frame for a given configuration
//   - DEFAULT_FRAME_CYCLES : frame length of the default configuration
package fifo_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Start + data + optional parity + stop, each held for cpb clocks.
    function automatic int frame_cycles(input int dw, input int cpb, input int pen);
        return (2 + dw + ((pen != 0) ? 1 : 0)) * cpb;
    endfunction

    localparam int DEFAULT_FRAME_CYCLES = frame_cycles(4, 4, 1);

endpackage

// File: rtl/fifo_nibble_tx_bit_timer.sv
// bit_timer
// Counts clk cycles within one serial bit period.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   run      : count while high, hold at zero while low
//   bit_end  : high on the last cycle of the current bit
//   near_end : high on the cycle before the last cycle of a bit
//              (always high when a bit lasts a single cycle)
module bit_timer #(
    parameter int CLKS_PER_BIT = 4,
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end,
    output logic near_end
);

    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] NEAR = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

    logic [CW-1:0] count;

    // Free-running bit counter that wraps at the end of every bit and
    // parks at zero whenever the transmitter is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!run || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_end  = run && (count == LAST);
    assign near_end = (CLKS_PER_BIT == 1) ? 1'b1 : (run && (count == NEAR));

endmodule

// File: rtl/fifo_nibble_tx.sv
// fifo_nibble_tx
// Pops words from a first-word-fall-through FIFO and sends each one as a
// serial frame: start(0), data LSB first, optional even parity, stop(1).
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   en         : allows a new frame to start
//   fifo_empty : FIFO empty flag
//   fifo_rdata : FIFO head word (valid while fifo_empty is low)
//   fifo_rinc  : one-cycle pop strobe
//   tx         : serial line, idle high, registered
//   busy       : high for every cycle of a frame, registered
//   frame_done : pulse on the last stop-bit cycle, registered
module fifo_nibble_tx
    import fifo_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rinc,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    tx_state_t             state, state_next;
    logic [DATA_WIDTH-1:0] shreg, shreg_next;
    logic [IW-1:0]         bit_idx, bit_idx_next;
    logic                  par, par_next;
    logic                  ready;
    logic                  can_launch;
    logic                  launch;
    logic                  tx_next, busy_next, done_next;
    logic                  bit_end, near_end;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (state != IDLE),
        .bit_end (bit_end),
        .near_end(near_end)
    );

    // Next-state logic. A launch (pop + capture) is allowed from IDLE or on
    // the final stop cycle so consecutive frames abut with no idle gap.
    // The registered outputs are computed from the next state so that
    // tx/busy/frame_done line up with the state they describe.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_idx_next = bit_idx;
        par_next     = par;
        launch       = 1'b0;
        can_launch   = ready && en && !fifo_empty;

        case (state)
            IDLE: begin
                if (can_launch) launch = 1'b1;
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_next = shreg >> 1;
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_next = bit_idx + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (can_launch) launch = 1'b1;
                    else            state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (launch) begin
            state_next   = START;
            shreg_next   = fifo_rdata;
            par_next     = ^fifo_rdata;
            bit_idx_next = '0;
        end

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            PARITY:  tx_next = par_next;
            default: tx_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE);
        // Last stop cycle: either a one-cycle bit being entered, or the
        // timer is one cycle away from the end of the stop bit.
        done_next = (state_next == STOP) &&
                    ((CLKS_PER_BIT == 1) || ((state == STOP) && near_end));
    end

    // The pop strobe is combinational so the word is captured in the same
    // cycle the FIFO is told to advance.
    assign fifo_rinc = launch && !rst;

    // State and output registers. 'ready' blocks a pop on the first cycle
    // after reset so all outputs sit at reset values for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            par        <= 1'b0;
            ready      <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            bit_idx    <= bit_idx_next;
            par        <= par_next;
            ready      <= 1'b1;
            tx         <= tx_next;
            busy       <= busy_next;
            frame_done <= done_next;
        end
    end

endmodule

// File: tb/tb_fifo_nibble_tx.sv
// tb_fifo_nibble_tx
// Drives two transmitters (4/4/parity and 4/1/no-parity) from FIFO queues
// held in the bench and compares every cycle against a frame-schedule model.
module tb_fifo_nibble_tx;

    logic       clk;
    logic       rst;
    logic       en;
    logic       fifo_empty0, fifo_empty1;
    logic [3:0] fifo_rdata0, fifo_rdata1;
    logic       fifo_rinc0, fifo_rinc1;
    logic       tx0, tx1;
    logic       busy0, busy1;
    logic       frame_done0, frame_done1;

    int checks;
    int failures;

    logic [3:0] q0[$];
    logic [3:0] q1[$];

    // Model state: upcoming tx bits (index 0 = current cycle) and how many
    // cycles of frame remain, per instance.
    logic [63:0] m_bits[2];
    int          m_rem[2];
    bit          armed;
    bit          started;
    bit          rinc_seen[2];
    int          rinc_cnt[2];
    int          run_len[2];
    int          last_run[2];
    logic        act_tx[2], act_busy[2], act_done[2], act_rinc[2];
    logic [3:0]  head[2];
    logic        empty[2];
    logic        exp_rinc, exp_tx;

    fifo_nibble_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
        .clk(clk), .rst(rst), .en(en),
        .fifo_empty(fifo_empty0), .fifo_rdata(fifo_rdata0), .fifo_rinc(fifo_rinc0),
        .tx(tx0), .busy(busy0), .frame_done(frame_done0)
    );

    fifo_nibble_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
        .clk(clk), .rst(rst), .en(en),
        .fifo_empty(fifo_empty1), .fifo_rdata(fifo_rdata1), .fifo_rinc(fifo_rinc1),
        .tx(tx1), .busy(busy1), .frame_done(frame_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int pen_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int frame_len(input int cpb, input int pen);
        return (2 + 4 + pen) * cpb;
    endfunction

    // Serial waveform of one frame, bit i of the result = tx on frame cycle i+1.
    function automatic logic [63:0] frame_bits(input logic [3:0] w, input int cpb, input int pen);
        logic [63:0] v;
        int          pos;
        logic        b;
        bit          use_bit;
        v   = '0;
        pos = 0;
        for (int k = 0; k < 7; k++) begin
            use_bit = 1'b1;
            if (k == 0)      b = 1'b0;
            else if (k <= 4) b = w[k-1];
            else if (k == 5) begin
                b       = ^w;
                use_bit = (pen != 0);
            end else         b = 1'b1;
            if (use_bit) begin
                for (int c = 0; c < cpb; c++) begin
                    v[pos] = b;
                    pos++;
                end
            end
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input int n);
        rst = r;
        en  = e;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [3:0] w);
        q0.push_back(w);
        q1.push_back(w);
    endtask

    // FIFO emulation, behavioural model and per-cycle comparison.
    initial begin
        fifo_empty0 = 1'b1; fifo_rdata0 = '0;
        fifo_empty1 = 1'b1; fifo_rdata1 = '0;
        armed   = 1'b0;
        started = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_bits[k] = '0; m_rem[k] = 0; rinc_seen[k] = 1'b0;
            rinc_cnt[k] = 0; run_len[k] = 0; last_run[k] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (rinc_seen[0] && q0.size() > 0) void'(q0.pop_front());
            if (rinc_seen[1] && q1.size() > 0) void'(q1.pop_front());
            #2;
            fifo_empty0 = (q0.size() == 0);
            fifo_rdata0 = (q0.size() > 0) ? q0[0] : 4'($urandom);
            fifo_empty1 = (q1.size() == 0);
            fifo_rdata1 = (q1.size() > 0) ? q1[0] : 4'($urandom);
            @(negedge clk);
            act_tx[0] = tx0; act_busy[0] = busy0; act_done[0] = frame_done0; act_rinc[0] = fifo_rinc0;
            act_tx[1] = tx1; act_busy[1] = busy1; act_done[1] = frame_done1; act_rinc[1] = fifo_rinc1;
            head[0] = fifo_rdata0; empty[0] = fifo_empty0;
            head[1] = fifo_rdata1; empty[1] = fifo_empty1;
            for (int k = 0; k < 2; k++) begin
                exp_rinc = !rst && armed && en && !empty[k] && (m_rem[k] <= 1);
                exp_tx   = (m_rem[k] > 0) ? m_bits[k][0] : 1'b1;
                if (started) begin
                    checkOutput($sformatf("fifo_rinc[%0d]", k), 64'(act_rinc[k]), 64'(exp_rinc));
                    checkOutput($sformatf("tx[%0d]", k), 64'(act_tx[k]), 64'(exp_tx));
                    checkOutput($sformatf("busy[%0d]", k), 64'(act_busy[k]), 64'(m_rem[k] > 0));
                    checkOutput($sformatf("frame_done[%0d]", k), 64'(act_done[k]), 64'(m_rem[k] == 1));
                    if (act_rinc[k] === 1'b1) rinc_cnt[k]++;
                    if (act_busy[k] === 1'b1) run_len[k]++;
                    else if (run_len[k] > 0) begin
                        last_run[k] = run_len[k];
                        run_len[k]  = 0;
                    end
                end
                rinc_seen[k] = (act_rinc[k] === 1'b1);
                if (rst) begin
                    m_rem[k] = 0;
                end else begin
                    if (m_rem[k] > 0) begin
                        m_bits[k] = m_bits[k] >> 1;
                        m_rem[k]--;
                    end
                    if (exp_rinc) begin
                        m_bits[k] = frame_bits(head[k], cpb_of(k), pen_of(k));
                        m_rem[k]  = frame_len(cpb_of(k), pen_of(k));
                    end
                end
            end
            armed = !rst;
            if (rst) started = 1'b1;
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        int   base0, base1;
        logic r, e;
        logic [63:0] lit;
        checks   = 0;
        failures = 0;

        applyStimulus(1'b1, 1'b1, 3);

        lit = frame_bits(4'hA, 4, 1);
        checkOutput("model_frame_A", lit, 64'h0F0F0F00);
        lit = frame_bits(4'h5, 1, 0);
        checkOutput("model_frame_5_noparity", lit, 64'h2A);
        lit = frame_bits(4'h3, 4, 1);
        checkOutput("model_frame_3", lit, 64'hF000FF0);
        lit = frame_bits(4'hF, 4, 1);
        checkOutput("model_frame_F", lit, 64'hF0FFFF0);
        lit = frame_bits(4'h0, 4, 1);
        checkOutput("model_frame_0", lit, 64'hF000000);
        checkOutput("model_len_default", 64'(frame_len(4, 1)), 64'd28);
        checkOutput("model_len_fast", 64'(frame_len(1, 0)), 64'd6);

        $display("[TB] empty FIFO with en=1");
        applyStimulus(1'b0, 1'b1, 100);
        checkOutput("idle_pops0", 64'(rinc_cnt[0]), 64'd0);
        checkOutput("idle_pops1", 64'(rinc_cnt[1]), 64'd0);

        $display("[TB] single word 4'hA");
        base0 = rinc_cnt[0]; base1 = rinc_cnt[1];
        push_word(4'hA);
        applyStimulus(1'b0, 1'b1, 40);
        checkOutput("single_pops0", 64'(rinc_cnt[0] - base0), 64'd1);
        checkOutput("single_pops1", 64'(rinc_cnt[1] - base1), 64'd1);
        checkOutput("single_busy0", 64'(last_run[0]), 64'd28);
        checkOutput("single_busy1", 64'(last_run[1]), 64'd6);

        $display("[TB] back-to-back 3, F, 0");
        base0 = rinc_cnt[0]; base1 = rinc_cnt[1];
        push_word(4'h3); push_word(4'hF); push_word(4'h0);
        applyStimulus(1'b0, 1'b1, 100);
        checkOutput("b2b_pops0", 64'(rinc_cnt[0] - base0), 64'd3);
        checkOutput("b2b_pops1", 64'(rinc_cnt[1] - base1), 64'd3);
        checkOutput("b2b_busy0", 64'(last_run[0]), 64'd84);
        checkOutput("b2b_busy1", 64'(last_run[1]), 64'd18);

        $display("[TB] en drop mid-frame");
        base0 = rinc_cnt[0];
        push_word(4'($urandom)); push_word(4'($urandom));
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 60);
        checkOutput("en_off_pops0", 64'(rinc_cnt[0] - base0), 64'd1);
        checkOutput("en_off_busy0", 64'(last_run[0]), 64'd28);
        applyStimulus(1'b0, 1'b1, 40);
        checkOutput("en_on_pops0", 64'(rinc_cnt[0] - base0), 64'd2);

        $display("[TB] reset mid-frame");
        base0 = rinc_cnt[0];
        push_word(4'($urandom)); push_word(4'($urandom));
        applyStimulus(1'b0, 1'b1, 12);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 60);
        checkOutput("rst_pops0", 64'(rinc_cnt[0] - base0), 64'd2);
        checkOutput("rst_drained0", 64'(q0.size()), 64'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0 && q0.size() < 6) push_word(4'($urandom));
            r = ($urandom_range(0, 249) == 0);
            e = ($urandom_range(0, 9) != 0);
            applyStimulus(r, e, 1);
        end
        applyStimulus(1'b0, 1'b1, 200);
        checkOutput("final_drained0", 64'(q0.size()), 64'd0);
        checkOutput("final_drained1", 64'(q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
